pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Sits beside the forwarding unit and drives the write-enables and flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves four events in fixed priority: HALT retirement, data-memory wait with timeout, taken branch/jump in EX, and load-use hazard.
- Also keeps saturating performance counters.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 34 +++
 rtl/pipe_hazard_ctrl_if.sv | 49 ++++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// The stage-control vector is ordered {PC_WE, IF_ID_WE, ID_EX_WE, EX_MEM_WE, MEM_WB_WE, IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH}.
package pipe_ctrl_pkg;

    localparam int DEF_MEM_TIMEOUT = 16;
    localparam int DEF_CNT_W       = 32;
    localparam int REG_ADDR_W      = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

    typedef logic [7:0] ctrl_t;

    localparam ctrl_t CTRL_NORMAL   = 8'b11111_000;
    localparam ctrl_t CTRL_FREEZE   = 8'b00001_001;
    localparam ctrl_t CTRL_BRANCH   = 8'b11111_110;
    localparam ctrl_t CTRL_LOAD_USE = 8'b00111_010;
    localparam ctrl_t CTRL_HALTED   = 8'b00000_000;
    localparam ctrl_t CTRL_RESET    = 8'b00000_111;

    // A taken branch squashes the ID instruction, so it wins over a load-use stall.
    function automatic ctrl_t run_pattern(input logic br_taken, input logic luh);
        if (br_taken) begin
            return CTRL_BRANCH;
        end else if (luh) begin
            return CTRL_LOAD_USE;
        end
        return CTRL_NORMAL;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
// The slave modport is the controller; the master modport is the pipeline that feeds it.
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic [REG_ADDR_W-1:0] ID_RA1;
    logic [REG_ADDR_W-1:0] ID_RA2;
    logic                  ID_USE_RA1;
    logic                  ID_USE_RA2;
    logic [REG_ADDR_W-1:0] EX_WA;
    logic                  EX_MEM_READ;
    logic                  EX_BR_TAKEN;
    logic                  MEM_REQ;
    logic                  DMEM_READY;
    logic                  WB_HALT;

    logic PC_WE;
    logic IF_ID_WE;
    logic ID_EX_WE;
    logic EX_MEM_WE;
    logic MEM_WB_WE;
    logic IF_ID_FLUSH;
    logic ID_EX_FLUSH;
    logic MEM_WB_FLUSH;
    logic HALTED;
    logic MEM_ERR;
    logic [CNT_W-1:0] CYC_CNT;
    logic [CNT_W-1:0] STALL_CNT;
    logic [CNT_W-1:0] FLUSH_CNT;

    modport master (
        output ID_RA1, ID_RA2, ID_USE_RA1, ID_USE_RA2, EX_WA, EX_MEM_READ,
               EX_BR_TAKEN, MEM_REQ, DMEM_READY, WB_HALT,
        input  PC_WE, IF_ID_WE, ID_EX_WE, EX_MEM_WE, MEM_WB_WE,
               IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH,
               HALTED, MEM_ERR, CYC_CNT, STALL_CNT, FLUSH_CNT
    );

    modport slave (
        input  ID_RA1, ID_RA2, ID_USE_RA1, ID_USE_RA2, EX_WA, EX_MEM_READ,
               EX_BR_TAKEN, MEM_REQ, DMEM_READY, WB_HALT,
        output PC_WE, IF_ID_WE, ID_EX_WE, EX_MEM_WE, MEM_WB_WE,
               IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH,
               HALTED, MEM_ERR, CYC_CNT, STALL_CNT, FLUSH_CNT
    );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detect: the ID instruction reads the register a load in EX is about to write.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_wa,
    input  logic [REG_ADDR_W-1:0] i_id_ra1,
    input  logic [REG_ADDR_W-1:0] i_id_ra2,
    input  logic                  i_id_use_ra1,
    input  logic                  i_id_use_ra2,
    output logic                  o_luh
);
    logic w_hit_ra1;
    logic w_hit_ra2;

    assign w_hit_ra1 = i_id_use_ra1 && (i_id_ra1 == i_ex_wa);
    assign w_hit_ra2 = i_id_use_ra2 && (i_id_ra2 == i_ex_wa);

    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    assign o_luh = i_ex_mem_read && (i_ex_wa != '0) && (w_hit_ra1 || w_hit_ra2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: HALT, data-memory wait/timeout,
// taken branch and load-use, plus saturating performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RSTn,
    pipe_hazard_ctrl_if.slave bus,
    output state_t            o_dbg_state
);
    localparam int              WC_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    state_t           r_state;
    logic [WC_W-1:0]  r_wait_cnt;
    logic             r_halted;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic            w_luh;
    ctrl_t           w_ctrl;
    state_t          w_next_state;
    logic [WC_W-1:0] w_wait_next;
    logic            w_err_set;
    logic            w_stall;
    logic            w_flush;

    load_use_detect u_load_use_detect (
        .i_ex_mem_read (bus.EX_MEM_READ),
        .i_ex_wa       (bus.EX_WA),
        .i_id_ra1      (bus.ID_RA1),
        .i_id_ra2      (bus.ID_RA2),
        .i_id_use_ra1  (bus.ID_USE_RA1),
        .i_id_use_ra2  (bus.ID_USE_RA2),
        .o_luh         (w_luh)
    );

    always_comb begin
        w_ctrl       = CTRL_NORMAL;
        w_next_state = r_state;
        w_wait_next  = r_wait_cnt;
        w_err_set    = 1'b0;
        w_stall      = 1'b0;
        w_flush      = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (bus.WB_HALT) begin
                    w_ctrl       = CTRL_NORMAL;
                    w_next_state = ST_HALTED;
                end else if (bus.MEM_REQ && !bus.DMEM_READY) begin
                    w_ctrl       = CTRL_FREEZE;
                    w_wait_next  = '0;
                    w_next_state = ST_MEM_WAIT;
                    w_stall      = 1'b1;
                end else begin
                    w_ctrl  = run_pattern(bus.EX_BR_TAKEN, w_luh);
                    w_flush = bus.EX_BR_TAKEN;
                    w_stall = !bus.EX_BR_TAKEN && w_luh;
                end
            end

            ST_MEM_WAIT: begin
                if (bus.WB_HALT) begin
                    w_ctrl       = CTRL_HALTED;
                    w_next_state = ST_HALTED;
                end else if (bus.DMEM_READY) begin
                    // The access completes this cycle, so branch/load-use resolve immediately.
                    w_ctrl       = run_pattern(bus.EX_BR_TAKEN, w_luh);
                    w_flush      = bus.EX_BR_TAKEN;
                    w_stall      = !bus.EX_BR_TAKEN && w_luh;
                    w_next_state = ST_RUN;
                end else if (r_wait_cnt == WC_LAST) begin
                    w_ctrl       = CTRL_FREEZE;
                    w_err_set    = 1'b1;
                    w_stall      = 1'b1;
                    w_next_state = ST_HALTED;
                end else begin
                    w_ctrl      = CTRL_FREEZE;
                    w_stall     = 1'b1;
                    w_wait_next = r_wait_cnt + WC_W'(1);
                end
            end

            ST_HALTED: begin
                w_ctrl = CTRL_HALTED;
            end

            default: begin
                w_ctrl       = CTRL_HALTED;
                w_next_state = ST_RUN;
            end
        endcase

        // Reset holds every stage register and forces bubbles into the flushable ones.
        if (!RSTn) begin
            w_ctrl = CTRL_RESET;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_halted    <= 1'b0;
            r_mem_err   <= 1'b0;
            r_cyc_cnt   <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_next;
            r_halted   <= (w_next_state == ST_HALTED);
            if (w_err_set) begin
                r_mem_err <= 1'b1;
            end
            if ((r_state != ST_HALTED) && (r_cyc_cnt != '1)) begin
                r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign {bus.PC_WE, bus.IF_ID_WE, bus.ID_EX_WE, bus.EX_MEM_WE, bus.MEM_WB_WE,
            bus.IF_ID_FLUSH, bus.ID_EX_FLUSH, bus.MEM_WB_FLUSH} = w_ctrl;

    assign bus.HALTED    = r_halted;
    assign bus.MEM_ERR   = r_mem_err;
    assign bus.CYC_CNT   = r_cyc_cnt;
    assign bus.STALL_CNT = r_stall_cnt;
    assign bus.FLUSH_CNT = r_flush_cnt;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic against a cycle-level model.
// A second instance with 4-bit counters shares the same inputs to exercise saturation.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int T   = 4;
    localparam int CW  = 16;
    localparam int CWS = 4;

    localparam logic [7:0] P_NORMAL   = 8'hF8;
    localparam logic [7:0] P_FREEZE   = 8'h09;
    localparam logic [7:0] P_BRANCH   = 8'hFE;
    localparam logic [7:0] P_LOADUSE  = 8'h3A;
    localparam logic [7:0] P_HALT     = 8'h00;
    localparam logic [7:0] P_RESET    = 8'h07;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;

    pipe_hazard_ctrl_if #(.CNT_W(CW))  bus ();
    pipe_hazard_ctrl_if #(.CNT_W(CWS)) bus_s ();

    state_t dbg_state;
    state_t dbg_state_s;

    assign bus_s.ID_RA1      = bus.ID_RA1;
    assign bus_s.ID_RA2      = bus.ID_RA2;
    assign bus_s.ID_USE_RA1  = bus.ID_USE_RA1;
    assign bus_s.ID_USE_RA2  = bus.ID_USE_RA2;
    assign bus_s.EX_WA       = bus.EX_WA;
    assign bus_s.EX_MEM_READ = bus.EX_MEM_READ;
    assign bus_s.EX_BR_TAKEN = bus.EX_BR_TAKEN;
    assign bus_s.MEM_REQ     = bus.MEM_REQ;
    assign bus_s.DMEM_READY  = bus.DMEM_READY;
    assign bus_s.WB_HALT     = bus.WB_HALT;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CWS)) dut_sat (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .bus         (bus_s),
        .o_dbg_state (dbg_state_s)
    );

    // clock
    initial begin
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit m_stop;
    bit m_wait;
    bit m_err;
    int m_nr;
    int m_cyc;
    int m_stall;
    int m_flush;
    logic [7:0] last_ctrl;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] sat(input int v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (longint'(v) > mx) ? mx : longint'(v);
    endfunction

    function automatic bit model_luh();
        bit rd1, rd2;
        rd1 = bus.ID_USE_RA1 && (bus.ID_RA1 == bus.EX_WA);
        rd2 = bus.ID_USE_RA2 && (bus.ID_RA2 == bus.EX_WA);
        return bus.EX_MEM_READ && (bus.EX_WA != 0) && (rd1 || rd2);
    endfunction

    task automatic set_in(input int ra1, input int ra2, input bit u1, input bit u2, input int wa,
                          input bit mrd, input bit br, input bit req, input bit rdy, input bit halt);
        bus.ID_RA1      = 5'(ra1);
        bus.ID_RA2      = 5'(ra2);
        bus.ID_USE_RA1  = u1;
        bus.ID_USE_RA2  = u2;
        bus.EX_WA       = 5'(wa);
        bus.EX_MEM_READ = mrd;
        bus.EX_BR_TAKEN = br;
        bus.MEM_REQ     = req;
        bus.DMEM_READY  = rdy;
        bus.WB_HALT     = halt;
    endtask

    task automatic model_reset();
        m_stop  = 0;
        m_wait  = 0;
        m_err   = 0;
        m_nr    = 0;
        m_cyc   = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // One clock cycle: check outputs against the model, advance the model, cross the edge.
    task automatic step();
        logic [7:0] exp_c, act_c, act_s;
        bit was_stop;
        bit hold;
        #1;
        check("halted", bus.HALTED, m_stop);
        check("mem_err", bus.MEM_ERR, m_err);
        check("state", dbg_state, m_stop ? 2 : (m_wait ? 1 : 0));
        check("cyc_cnt", bus.CYC_CNT, sat(m_cyc, CW));
        check("stall_cnt", bus.STALL_CNT, sat(m_stall, CW));
        check("flush_cnt", bus.FLUSH_CNT, sat(m_flush, CW));
        check("sat_cyc_cnt", bus_s.CYC_CNT, sat(m_cyc, CWS));
        check("sat_stall_cnt", bus_s.STALL_CNT, sat(m_stall, CWS));
        check("sat_flush_cnt", bus_s.FLUSH_CNT, sat(m_flush, CWS));

        was_stop = m_stop;
        hold = m_wait ? !bus.DMEM_READY : (bus.MEM_REQ && !bus.DMEM_READY);
        if (m_stop) begin
            exp_c = P_HALT;
        end else if (bus.WB_HALT) begin
            exp_c  = m_wait ? P_HALT : P_NORMAL;
            m_stop = 1;
            m_wait = 0;
        end else if (hold) begin
            exp_c = P_FREEZE;
            if (!m_wait) m_nr = 0;
            m_nr++;
            m_stall++;
            if (m_nr == 1 + T) begin
                m_err  = 1;
                m_stop = 1;
                m_wait = 0;
            end else begin
                m_wait = 1;
            end
        end else begin
            m_wait = 0;
            if (bus.EX_BR_TAKEN) begin
                exp_c = P_BRANCH;
                m_flush++;
            end else if (model_luh()) begin
                exp_c = P_LOADUSE;
                m_stall++;
            end else begin
                exp_c = P_NORMAL;
            end
        end
        if (!was_stop) m_cyc++;

        act_c = {bus.PC_WE, bus.IF_ID_WE, bus.ID_EX_WE, bus.EX_MEM_WE, bus.MEM_WB_WE,
                 bus.IF_ID_FLUSH, bus.ID_EX_FLUSH, bus.MEM_WB_FLUSH};
        act_s = {bus_s.PC_WE, bus_s.IF_ID_WE, bus_s.ID_EX_WE, bus_s.EX_MEM_WE, bus_s.MEM_WB_WE,
                 bus_s.IF_ID_FLUSH, bus_s.ID_EX_FLUSH, bus_s.MEM_WB_FLUSH};
        last_ctrl = act_c;
        check("ctrl", act_c, exp_c);
        check("sat_ctrl", act_s, exp_c);
        @(negedge CLK);
    endtask

    // Called at a falling edge; asserts reset mid-cycle, checks reset values, releases off-edge.
    task automatic do_reset();
        logic [7:0] act_c;
        #2;
        RSTn = 1'b0;
        #1;
        act_c = {bus.PC_WE, bus.IF_ID_WE, bus.ID_EX_WE, bus.EX_MEM_WE, bus.MEM_WB_WE,
                 bus.IF_ID_FLUSH, bus.ID_EX_FLUSH, bus.MEM_WB_FLUSH};
        check("rst_ctrl", act_c, P_RESET);
        check("rst_halted", bus.HALTED, 0);
        check("rst_mem_err", bus.MEM_ERR, 0);
        check("rst_cyc", bus.CYC_CNT, 0);
        check("rst_stall", bus.STALL_CNT, 0);
        check("rst_flush", bus.FLUSH_CNT, 0);
        check("rst_state", dbg_state, 0);
        @(negedge CLK);
        #2;
        RSTn = 1'b1;
        model_reset();
    endtask

    task automatic rand_in(inout int stubborn);
        bit rdy;
        if (stubborn > 0) begin
            rdy = 0;
            stubborn--;
        end else begin
            rdy = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 40) == 0) stubborn = $urandom_range(2, 6);
        end
        set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, 3), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0), rdy,
               ($urandom_range(0, 250) == 0));
    endtask

    initial begin
        int stubborn;
        int stopped_for;
        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge CLK);
        do_reset();

        // load-use, then the same with EX_WA = 0
        set_in(0, 5, 0, 1, 5, 1, 0, 0, 1, 0);
        step();
        check("lu_pattern", last_ctrl, P_LOADUSE);
        check("lu_stall_cnt", bus.STALL_CNT, 1);
        set_in(0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
        step();
        check("lu_r0_pattern", last_ctrl, P_NORMAL);
        check("lu_r0_stall_cnt", bus.STALL_CNT, 1);

        // branch with a simultaneous load-use condition
        set_in(0, 5, 0, 1, 5, 1, 1, 0, 1, 0);
        step();
        check("br_pattern", last_ctrl, P_BRANCH);
        check("br_flush_cnt", bus.FLUSH_CNT, 1);
        check("br_stall_cnt", bus.STALL_CNT, 1);

        // memory wait released after three freeze cycles
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            step();
            check("mw_freeze", last_ctrl, P_FREEZE);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step();
        check("mw_release", last_ctrl, P_NORMAL);
        check("mw_stall_cnt", bus.STALL_CNT, 4);
        check("mw_state_run", dbg_state, 0);

        // memory timeout: 1 + T freeze cycles then halt with error
        for (int i = 0; i < 1 + T; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            step();
            check("to_freeze", last_ctrl, P_FREEZE);
        end
        check("to_halted", bus.HALTED, 1);
        check("to_mem_err", bus.MEM_ERR, 1);
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
            step();
            check("to_halt_pattern", last_ctrl, P_HALT);
        end
        check("to_cyc_frozen", bus.CYC_CNT, 12);
        do_reset();

        // HALT in WB, then reset mid-run
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step();
        check("halt_pattern", last_ctrl, P_NORMAL);
        check("halt_halted", bus.HALTED, 1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        do_reset();

        // counter saturation on the narrow instance
        for (int i = 0; i < 20; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            step();
        end
        check("sat_cyc_hold", bus_s.CYC_CNT, 15);
        check("wide_cyc_20", bus.CYC_CNT, 20);

        // random traffic
        stubborn    = 0;
        stopped_for = 0;
        for (int c = 0; c < 3000; c++) begin
            if (m_stop) stopped_for++;
            if (stopped_for > 3 || $urandom_range(0, 400) == 0) begin
                stopped_for = 0;
                stubborn    = 0;
                do_reset();
            end
            rand_in(stubborn);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
